// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared definitions for the IF stage: the NOP encoding, the default halt
//   word, the FSM state encoding, the PC update selector and the IF/ID update
//   selector, plus a word-alignment helper.
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   // Core launch/park states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } fetch_state_e;

   // PC next-value select
   typedef enum logic [1:0] {
      PC_HOLD     = 2'b00,
      PC_INCR     = 2'b01,
      PC_REDIRECT = 2'b10
   } pc_sel_e;

   // IF/ID register update select
   typedef enum logic [1:0] {
      IFID_HOLD = 2'b00,
      IFID_LOAD = 2'b01,
      IFID_NOP  = 2'b10
   } ifid_op_e;

   // Instruction addresses are always word aligned
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
//   Program counter register for the IF stage. Holds, increments by 4
//   (modulo 2^32) or loads a word-aligned redirect target.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (PC <= RESET_PC, aligned)
//   pc_sel    in   hold / increment / redirect select
//   new_pc    in   redirect target (low two bits are discarded)
//   pc        out  current PC (registered)
//   pc_plus4  out  pc + 4, wrapping at 2^32
// -----------------------------------------------------------------------------
module fetch_pc_reg
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  pc_sel_e     pc_sel,
   input  logic [31:0] new_pc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;

   // Sequential PC increment; the carry out of bit 31 is dropped on purpose
   always_comb begin
      pc_plus4 = pc_r + 32'd4;
   end

   // Next-PC selection
   always_comb begin
      pc_next_s = pc_r;
      case (pc_sel)
         PC_HOLD:     pc_next_s = pc_r;
         PC_INCR:     pc_next_s = pc_plus4;
         PC_REDIRECT: pc_next_s = align_word(new_pc);
         default:     pc_next_s = pc_r;
      endcase
   end

   // PC state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r <= align_word(RESET_PC);
      end else begin
         pc_r <= pc_next_s;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Per-core IF stage: owns the PC (via fetch_pc_reg), reads instruction
//   memory combinationally, fills the IF/ID register for decode, and runs an
//   IDLE -> RUN -> HALT launch/park FSM. HALT is only left through Rst.
//
//   Build option: define FETCH_DELAY_SLOT_EN to keep the word fetched in the
//   redirect cycle as a delay slot; otherwise that word is squashed to a NOP.
//
// Ports:
//   Clk               in   rising-edge clock
//   Rst               in   asynchronous active-high reset
//   Start             in   leave IDLE and begin fetching (ignored elsewhere)
//   ID_stall          in   hold PC, IF/ID and count
//   ID_PCSrc          in   redirect to ID_new_PC (ignored while stalled)
//   ID_new_PC         in   redirect target
//   IF_imem_addr      out  fetch byte address (= PC)
//   IF_imem_data      in   instruction word at IF_imem_addr
//   IF_ID_Instruction out  IF/ID instruction, NOP when empty
//   IF_ID_PC4         out  PC+4 of the held instruction
//   IF_ID_Valid       out  IF/ID holds a real fetched instruction
//   IF_halted         out  core parked
//   IF_fetch_count    out  saturating count of valid IF/ID loads
// -----------------------------------------------------------------------------
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
   parameter int          CNT_W     = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             ID_stall,
   input  logic             ID_PCSrc,
   input  logic [31:0]      ID_new_PC,
   output logic [31:0]      IF_imem_addr,
   input  logic [31:0]      IF_imem_data,
   output logic [31:0]      IF_ID_Instruction,
   output logic [31:0]      IF_ID_PC4,
   output logic             IF_ID_Valid,
   output logic             IF_halted,
   output logic [CNT_W-1:0] IF_fetch_count
);

   fetch_state_e     state_r;
   fetch_state_e     state_next_s;
   pc_sel_e          pc_sel_s;
   ifid_op_e         ifid_op_s;
   logic             count_inc_s;
   logic [31:0]      pc_s;
   logic [31:0]      pc_plus4_s;
   logic [31:0]      ifid_instr_r;
   logic [31:0]      ifid_pc4_r;
   logic             ifid_valid_r;
   logic             halted_r;
   logic [CNT_W-1:0] fetch_count_r;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (Clk),
      .rst      (Rst),
      .pc_sel   (pc_sel_s),
      .new_pc   (ID_new_PC),
      .pc       (pc_s),
      .pc_plus4 (pc_plus4_s)
   );

   // FSM next state plus PC / IF/ID / counter controls.
   // In RUN the priority is stall > redirect > halt word > normal fetch, so a
   // halt word sitting in a redirect slot never parks the core.
   always_comb begin
      state_next_s = state_r;
      pc_sel_s     = PC_HOLD;
      ifid_op_s    = IFID_HOLD;
      count_inc_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ifid_op_s = IFID_NOP;
            if (Start) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ID_stall) begin
               ifid_op_s = IFID_HOLD;
            end else if (ID_PCSrc) begin
               pc_sel_s = PC_REDIRECT;
`ifdef FETCH_DELAY_SLOT_EN
               ifid_op_s   = IFID_LOAD;
               count_inc_s = 1'b1;
`else
               ifid_op_s   = IFID_NOP;
`endif
            end else if (IF_imem_data == HALT_WORD) begin
               ifid_op_s    = IFID_NOP;
               state_next_s = ST_HALT;
            end else begin
               pc_sel_s    = PC_INCR;
               ifid_op_s   = IFID_LOAD;
               count_inc_s = 1'b1;
            end
         end
         ST_HALT: begin
            ifid_op_s    = IFID_NOP;
            state_next_s = ST_HALT;
         end
         default: begin
            ifid_op_s    = IFID_NOP;
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and halted flag; the flag tracks the state being entered
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r  <= ST_IDLE;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         halted_r <= (state_next_s == ST_HALT);
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ifid_instr_r <= NOP_WORD;
         ifid_pc4_r   <= 32'h0000_0000;
         ifid_valid_r <= 1'b0;
      end else begin
         case (ifid_op_s)
            IFID_LOAD: begin
               ifid_instr_r <= IF_imem_data;
               ifid_pc4_r   <= pc_plus4_s;
               ifid_valid_r <= 1'b1;
            end
            IFID_NOP: begin
               ifid_instr_r <= NOP_WORD;
               ifid_pc4_r   <= 32'h0000_0000;
               ifid_valid_r <= 1'b0;
            end
            IFID_HOLD: begin
               ifid_instr_r <= ifid_instr_r;
               ifid_pc4_r   <= ifid_pc4_r;
               ifid_valid_r <= ifid_valid_r;
            end
            default: begin
               ifid_instr_r <= NOP_WORD;
               ifid_pc4_r   <= 32'h0000_0000;
               ifid_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Saturating fetched-instruction counter
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fetch_count_r <= {CNT_W{1'b0}};
      end else if (count_inc_s && (fetch_count_r != {CNT_W{1'b1}})) begin
         fetch_count_r <= fetch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         fetch_count_r <= fetch_count_r;
      end
   end

   assign IF_imem_addr      = pc_s;
   assign IF_ID_Instruction = ifid_instr_r;
   assign IF_ID_PC4         = ifid_pc4_r;
   assign IF_ID_Valid       = ifid_valid_r;
   assign IF_halted         = halted_r;
   assign IF_fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Table-driven, self-checking bench for instruction_fetch_unit. Each table
//   record carries one cycle of inputs and the outputs expected after that
//   clock edge; records are pushed to a scoreboard queue when driven and
//   popped/compared after the edge. Asynchronous reset is checked by hand.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] NH   = 32'h0000_0001;  // unaligned: never matches
`ifdef FETCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   typedef struct {
      logic        start;
      logic        stall;
      logic        pcsrc;
      logic [31:0] new_pc;
      logic [31:0] halt_at;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_valid;
      logic        e_halted;
      logic [31:0] e_cnt;
      logic [31:0] e_addr;
   } vec_t;

   logic        clk_s = 1'b0;
   logic        rst_s;
   logic        start_s;
   logic        stall_s;
   logic        pcsrc_s;
   logic [31:0] new_pc_s;
   logic [31:0] imem_addr_s;
   logic [31:0] imem_data_s;
   logic [31:0] instr_s;
   logic [31:0] pc4_s;
   logic        valid_s;
   logic        halted_s;
   logic [31:0] count_s;
   logic [31:0] halt_at_s;

   int n_cmp = 0;
   int n_err = 0;
   vec_t tbl_a[$];
   vec_t tbl_b[$];
   vec_t exp_q[$];

   instruction_fetch_unit dut (
      .Clk               (clk_s),
      .Rst               (rst_s),
      .Start             (start_s),
      .ID_stall          (stall_s),
      .ID_PCSrc          (pcsrc_s),
      .ID_new_PC         (new_pc_s),
      .IF_imem_addr      (imem_addr_s),
      .IF_imem_data      (imem_data_s),
      .IF_ID_Instruction (instr_s),
      .IF_ID_PC4         (pc4_s),
      .IF_ID_Valid       (valid_s),
      .IF_halted         (halted_s),
      .IF_fetch_count    (count_s)
   );

   always #5 clk_s = ~clk_s;

   // Memory contents: address 0 holds 32'h2008_0005, others follow a pattern
   function automatic logic [31:0] mw(input logic [31:0] a);
      return 32'h2008_0005 + {a[23:0], 8'h00};
   endfunction

   // Combinational instruction memory with one optional halt location
   always_comb begin
      imem_data_s = (imem_addr_s == halt_at_s) ? HALT : mw(imem_addr_s);
   end

   function automatic vec_t mk(input logic st, input logic sl, input logic ps,
                               input logic [31:0] np, input logic [31:0] ha,
                               input logic [31:0] ei, input logic [31:0] ep,
                               input logic ev, input logic eh,
                               input logic [31:0] ec, input logic [31:0] ea);
      vec_t v;
      v.start = st; v.stall = sl; v.pcsrc = ps; v.new_pc = np; v.halt_at = ha;
      v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_halted = eh;
      v.e_cnt = ec; v.e_addr = ea;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      cmp({tag, " instr"},  instr_s, 32'h0);
      cmp({tag, " pc4"},    pc4_s, 32'h0);
      cmp({tag, " valid"},  {31'h0, valid_s}, 32'h0);
      cmp({tag, " halted"}, {31'h0, halted_s}, 32'h0);
      cmp({tag, " count"},  count_s, 32'h0);
      cmp({tag, " addr"},   imem_addr_s, 32'h0);
   endtask

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      @(negedge clk_s);
      start_s = v.start; stall_s = v.stall; pcsrc_s = v.pcsrc;
      new_pc_s = v.new_pc; halt_at_s = v.halt_at;
      exp_q.push_back(v);
      @(posedge clk_s);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         cmp({tag, " instr"},  instr_s, e.e_instr);
         cmp({tag, " pc4"},    pc4_s, e.e_pc4);
         cmp({tag, " valid"},  {31'h0, valid_s}, {31'h0, e.e_valid});
         cmp({tag, " halted"}, {31'h0, halted_s}, {31'h0, e.e_halted});
         cmp({tag, " count"},  count_s, e.e_cnt);
         cmp({tag, " addr"},   imem_addr_s, e.e_addr);
      end
   endtask

   initial begin
      // Run A: launch, stall, redirect, squashed halt word, real halt
      tbl_a.push_back(mk(0,0,0,32'h0,NH, 32'h0,32'h0,0,0, 0,32'h0));        // idle
      tbl_a.push_back(mk(1,0,0,32'h0,NH, 32'h0,32'h0,0,0, 0,32'h0));        // start
      tbl_a.push_back(mk(0,0,0,32'h0,NH, 32'h2008_0005,32'h4,1,0, 1,32'h4));
      tbl_a.push_back(mk(1,0,0,32'h0,NH, mw(32'h4),32'h8,1,0, 2,32'h8));
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'h8),32'hC,1,0, 3,32'hC));
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'hC),32'h10,1,0, 4,32'h10));
      tbl_a.push_back(mk(0,1,1,32'h80,NH, mw(32'hC),32'h10,1,0, 4,32'h10)); // stall
      tbl_a.push_back(mk(0,1,0,32'h80,NH, mw(32'hC),32'h10,1,0, 4,32'h10));
      tbl_a.push_back(mk(0,1,1,32'h84,NH, mw(32'hC),32'h10,1,0, 4,32'h10));
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'h10),32'h14,1,0, 5,32'h14));
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'h14),32'h18,1,0, 6,32'h18));
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'h18),32'h1C,1,0, 7,32'h1C));
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'h1C),32'h20,1,0, 8,32'h20));
      tbl_a.push_back(mk(0,0,1,32'h40,NH, DS ? mw(32'h20) : 32'h0, DS ? 32'h24 : 32'h0,
                         DS,0, 8+DS,32'h40));                                 // redirect
      tbl_a.push_back(mk(0,0,0,32'h0,NH, mw(32'h40),32'h44,1,0, 9+DS,32'h44));
      tbl_a.push_back(mk(0,0,1,32'h28,32'h44, DS ? HALT : 32'h0, DS ? 32'h48 : 32'h0,
                         DS,0, 9+2*DS,32'h28));                               // halt in slot
      tbl_a.push_back(mk(0,0,0,32'h0,32'h30, mw(32'h28),32'h2C,1,0, 10+2*DS,32'h2C));
      tbl_a.push_back(mk(0,0,0,32'h0,32'h30, mw(32'h2C),32'h30,1,0, 11+2*DS,32'h30));
      tbl_a.push_back(mk(0,0,0,32'h0,32'h30, 32'h0,32'h0,0,1, 11+2*DS,32'h30)); // halt
      tbl_a.push_back(mk(1,0,0,32'h0,32'h30, 32'h0,32'h0,0,1, 11+2*DS,32'h30));
      tbl_a.push_back(mk(0,1,1,32'h80,32'h30, 32'h0,32'h0,0,1, 11+2*DS,32'h30));
      tbl_a.push_back(mk(0,0,1,32'h80,32'h30, 32'h0,32'h0,0,1, 11+2*DS,32'h30));

      // Run B: unaligned redirect, PC wrap at 2^32
      tbl_b.push_back(mk(1,0,0,32'h0,NH, 32'h0,32'h0,0,0, 0,32'h0));
      tbl_b.push_back(mk(0,0,1,32'h43,NH, DS ? mw(32'h0) : 32'h0, DS ? 32'h4 : 32'h0,
                         DS,0, DS,32'h40));
      tbl_b.push_back(mk(0,0,1,32'hFFFF_FFFC,NH, DS ? mw(32'h40) : 32'h0, DS ? 32'h44 : 32'h0,
                         DS,0, 2*DS,32'hFFFF_FFFC));
      tbl_b.push_back(mk(0,0,0,32'h0,NH, mw(32'hFFFF_FFFC),32'h0,1,0, 1+2*DS,32'h0));
      tbl_b.push_back(mk(0,0,0,32'h0,NH, mw(32'h0),32'h4,1,0, 2+2*DS,32'h4));

      rst_s = 1'b1; start_s = 1'b0; stall_s = 1'b0; pcsrc_s = 1'b0;
      new_pc_s = 32'h0; halt_at_s = NH;
      @(posedge clk_s);
      @(posedge clk_s);
      @(negedge clk_s);
      chk_reset("reset");
      rst_s = 1'b0;

      for (int i = 0; i < tbl_a.size(); i++) begin
         apply(tbl_a[i], $sformatf("A%0d", i));
      end

      // Rst releases the parked core back to reset state immediately
      @(negedge clk_s);
      start_s = 1'b0; stall_s = 1'b0; pcsrc_s = 1'b0; halt_at_s = NH;
      rst_s = 1'b1;
      #1;
      chk_reset("halt_rst");
      @(negedge clk_s);
      rst_s = 1'b0;

      for (int i = 0; i < tbl_b.size(); i++) begin
         apply(tbl_b[i], $sformatf("B%0d", i));
      end

      // Asynchronous reset in the middle of RUN, checked before the next edge
      #2;
      rst_s = 1'b1;
      #1;
      chk_reset("mid_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
